// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator with sub-word read-modify-write
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        misalign_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;

  // The wait gives up on the edge where the counter would become all-ones.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t                state, state_d;
  logic [TIMEOUT_W-1:0]  cnt;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           addr_q;
  logic [15:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_wdata_q;
  logic                  timeout_q;
  logic                  misalign_q;
  logic                  waiting;
  logic                  expired;
  logic                  misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;

  assign waiting = (state == RD) || (state == RMW_RD) || (state == WR);
  assign expired = waiting && !mem_ack_i && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (size_i == 2'b01) ? addr_i[0] :
                      (size_i[1] ? (addr_i[1:0] != 2'b00) : 1'b0);
`else
  assign misaligned = 1'b0;
`endif

  assign rdata_o     = rdata_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign timeout_o   = timeout_q && (state == DONE);
  assign misalign_o  = misalign_q && (state == DONE);

  // Lane extraction for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    ld_byte   = mem_rdata_i[7:0];
    merge_val = mem_rdata_i;
    case (addr_q[1:0])
      2'b00: ld_byte = mem_rdata_i[7:0];
      2'b01: ld_byte = mem_rdata_i[15:8];
      2'b10: ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00: load_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01: load_val = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_val = mem_rdata_i;
    endcase
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'b00: merge_val[7:0]   = wdata_q[7:0];
        2'b01: merge_val[15:8]  = wdata_q[7:0];
        2'b10: merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = req_i;
        if (req_i) begin
          if (misaligned)     state_d = DONE;
          else if (!we_i)     state_d = RD;
          else if (size_i[1]) state_d = WR;
          else                state_d = RMW_RD;
        end
      end
      RD: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ack_i || expired) state_d = DONE;
      end
      RMW_RD: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ack_i)    state_d = WR;
        else if (expired) state_d = DONE;
      end
      WR: begin
        stall_o     = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ack_i || expired) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      timeout_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (state_d != state) cnt <= '0;
      else if (waiting)     cnt <= cnt + CNT_ONE;
      case (state)
        IDLE: if (req_i) begin
          size_q     <= size_i;
          uns_q      <= unsigned_i;
          addr_q     <= addr_i;
          wdata_q    <= wdata_i[15:0];
          rdata_q    <= '0;
          timeout_q  <= 1'b0;
          misalign_q <= misaligned;
          if (we_i && size_i[1]) mem_wdata_q <= wdata_i;
        end
        RD: begin
          if (mem_ack_i)    rdata_q   <= load_val;
          else if (expired) timeout_q <= 1'b1;
        end
        RMW_RD: begin
          if (mem_ack_i)    mem_wdata_q <= merge_val;
          else if (expired) timeout_q   <= 1'b1;
        end
        WR: if (expired) timeout_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural word memory
module tb_load_store_unit;
  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, timeout_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_read_o, mem_write_o, mem_ack_i;

  load_store_unit #(.TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .done_o(done_o), .timeout_o(timeout_o), .misalign_o(misalign_o),
    .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          timeout;
    bit          misalign;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [0:63];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cycles = 0, wr_cycles = 0, rd_acks = 0, wr_acks = 0;
  int          unstable = 0, excl_viol = 0;
  logic [31:0] burst_addr, burst_wdata;

  // Memory: acks after ack_delay strobe cycles (negative = never), commits on ack.
  always @(negedge clk) begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if ((mem_read_o && mem_write_o) || ((mem_read_o || mem_write_o) && done_o)) excl_viol++;
    if (rst) begin
      wait_cnt = 0;
    end else if (mem_read_o || mem_write_o) begin
      if (wait_cnt == 0) begin
        burst_addr  = mem_addr_o;
        burst_wdata = mem_wdata_o;
      end else if (mem_addr_o !== burst_addr || (mem_write_o && mem_wdata_o !== burst_wdata)) begin
        unstable++;
      end
      if (mem_read_o) rd_cycles++;
      else            wr_cycles++;
      if (ack_delay >= 0 && wait_cnt >= ack_delay) begin
        mem_ack_i = 1'b1;
        if (mem_read_o) begin
          mem_rdata_i = mem[mem_addr_o[7:2]];
          rd_acks++;
        end else begin
          mem[mem_addr_o[7:2]] = mem_wdata_o;
          wr_acks++;
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic clear_counts();
    rd_cycles = 0; wr_cycles = 0; rd_acks = 0; wr_acks = 0; unstable = 0;
  endtask

  task automatic sb_drain(input int budget, output int lat);
    exp_t e;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin
        lat = i + 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_wait: no done_o within %0d cycles", budget);
      if (sb.size() > 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: done_o with no expected entry");
    end else begin
      e = sb.pop_front();
      if (e.chk_rdata) begin
        checks++;
        if (rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL rdata: got %h expected %h", rdata_o, e.rdata);
        end
      end
      checks++;
      if ({timeout_o, misalign_o} !== {e.timeout, e.misalign}) begin
        errors++;
        $display("FAIL flags: got timeout=%b misalign=%b expected timeout=%b misalign=%b",
                 timeout_o, misalign_o, e.timeout, e.misalign);
      end
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_to, input bit exp_ma,
                        output int lat);
    exp_t e;
    e.rdata = exp_rd; e.chk_rdata = !we; e.timeout = exp_to; e.misalign = exp_ma;
    sb.push_back(e);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    @(negedge clk);
    req_i = 1'b0;
    sb_drain(60, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdata_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h expected all 0", rdata_o, mem_addr_o, mem_wdata_o);
    end
    checks++;
    if ({stall_o, done_o, timeout_o, misalign_o, mem_read_o, mem_write_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {stall_o, done_o, timeout_o, misalign_o, mem_read_o, mem_write_o});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    int lat;
    ack_delay = 2;
    clear_counts();
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, lat);
    checks++;
    if (wr_cycles !== 3 || rd_cycles !== 0) begin
      errors++;
      $display("FAIL sw_strobes: got wr=%0d rd=%0d expected wr=3 rd=0", wr_cycles, rd_cycles);
    end
    checks++;
    if (unstable !== 0 || burst_addr !== 32'h10) begin
      errors++;
      $display("FAIL sw_addr: got addr=%h unstable=%0d expected 00000010 stable", burst_addr, unstable);
    end
    checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
    end
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, lat);
    ack_delay = 0;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL lw_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_subword_store();
    int lat;
    ack_delay = 0;
    mem[4] = 32'h11223344;
    clear_counts();
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, 32'h0, 1'b0, 1'b0, lat);
    checks++;
    if (rd_acks !== 1 || wr_acks !== 1 || mem[4] !== 32'h5A223344) begin
      errors++;
      $display("FAIL sb_rmw: got rd=%0d wr=%0d mem=%h expected 1 1 5a223344", rd_acks, wr_acks, mem[4]);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL sb_latency: got %0d expected 3", lat);
    end
    access(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF, 32'h0, 1'b0, 1'b0, lat);
    checks++;
    if (mem[4] !== 32'h5A22BEEF) begin
      errors++;
      $display("FAIL sh_mem: got %h expected 5a22beef", mem[4]);
    end
  endtask

  task automatic test_load_extend();
    int lat;
    ack_delay = 1;
    mem[4] = 32'h12F08000;
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, lat);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h00000080, 1'b0, 1'b0, lat);
    access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h000012F0, 1'b0, 1'b0, lat);
    access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF8000, 1'b0, 1'b0, lat);
    access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00008000, 1'b0, 1'b0, lat);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   dones = 0;
    ack_delay = 0;
    mem[4] = 32'hA0A0A0A0; mem[5] = 32'h0B0B0B0B; mem[6] = 32'hC1C2C3C4;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) begin
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
        addr_i = 32'h10 + 32'(4 * (k / 3));
        e.rdata = mem[4 + k / 3]; e.chk_rdata = 1'b1; e.timeout = 1'b0; e.misalign = 1'b0;
        sb.push_back(e);
      end
      #1;
      checks++;
      if (stall_o !== (k % 3 != 2)) begin
        errors++;
        $display("FAIL b2b_stall: cycle %0d got %b expected %b", k, stall_o, (k % 3 != 2));
      end
      checks++;
      if (done_o !== (k % 3 == 2)) begin
        errors++;
        $display("FAIL b2b_done: cycle %0d got %b expected %b", k, done_o, (k % 3 == 2));
      end
      if (done_o && sb.size() > 0) begin
        dones++;
        e = sb.pop_front();
        checks++;
        if (rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL b2b_rdata: cycle %0d got %h expected %h", k, rdata_o, e.rdata);
        end
      end
      @(negedge clk);
    end
    req_i = 1'b0;
    checks++;
    if (dones !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", dones);
    end
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    ack_delay = -1;
    mem[8] = 32'h77777777;
    clear_counts();
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, lat);
    checks++;
    if (rd_cycles !== 15) begin
      errors++;
      $display("FAIL to_lw_strobe: got %0d expected 15", rd_cycles);
    end
    clear_counts();
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b1, 1'b0, lat);
    checks++;
    if (wr_cycles !== 15 || mem[8] !== 32'h77777777) begin
      errors++;
      $display("FAIL to_sw: got wr=%0d mem=%h expected 15 77777777", wr_cycles, mem[8]);
    end
    clear_counts();
    access(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE, 32'h0, 1'b1, 1'b0, lat);
    checks++;
    if (rd_cycles !== 15 || wr_cycles !== 0 || mem[8] !== 32'h77777777) begin
      errors++;
      $display("FAIL to_sb: got rd=%0d wr=%0d mem=%h expected 15 0 77777777", rd_cycles, wr_cycles, mem[8]);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    int lat;
    ack_delay = -1;
    mem[4] = 32'hCAFEF00D;
    clear_counts();
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h11; wdata_i = 32'hA5;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got mem_read_o=%b expected 1", mem_read_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({stall_o, done_o, timeout_o, misalign_o, mem_read_o, mem_write_o} !== 6'b0 ||
        rdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h rdata=%h expected all 0",
               {stall_o, done_o, timeout_o, misalign_o, mem_read_o, mem_write_o}, mem_addr_o, rdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_acks !== 0 || wr_cycles !== 0 || mem[4] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_mid_nowrite: got wr=%0d mem=%h expected 0 cafef00d", wr_cycles, mem[4]);
    end
    ack_delay = 0;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, 32'h0, 1'b0, 1'b0, lat);
    checks++;
    if (mem[4] !== 32'h01020304) begin
      errors++;
      $display("FAIL rst_mid_sw: got %h expected 01020304", mem[4]);
    end
  endtask

  task automatic test_misalign();
    int lat;
    ack_delay = 0;
    mem[4] = 32'h89ABCDEF;
    clear_counts();
`ifdef LSU_MISALIGN_TRAP_EN
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b0, 1'b1, lat);
    access(1'b1, 2'b01, 1'b0, 32'h13, 32'h1111, 32'h0, 1'b0, 1'b1, lat);
    checks++;
    if (rd_cycles !== 0 || wr_cycles !== 0 || mem[4] !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL misalign_nomem: got rd=%0d wr=%0d mem=%h expected 0 0 89abcdef", rd_cycles, wr_cycles, mem[4]);
    end
`else
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h89ABCDEF, 1'b0, 1'b0, lat);
    access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h000089AB, 1'b0, 1'b0, lat);
    checks++;
    if (rd_cycles !== 2) begin
      errors++;
      $display("FAIL misalign_reads: got %0d expected 2", rd_cycles);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset();
    test_word();
    test_subword_store();
    test_load_extend();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_misalign();
    checks++;
    if (excl_viol !== 0) begin
      errors++;
      $display("FAIL strobe_excl: got %0d violations expected 0", excl_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
